// File: rtl/sram_access_ctrl.sv
// AHB-Lite slave in front of the four-bank single-port SRAM array.
// Word accesses take no wait states. Sub-word writes use read-modify-write.
module sram_access_ctrl #(
    parameter int SRAM_ADDR_WIDTH = 12,
    parameter int SRAM_DATA_WIDTH = 32
) (
    input  logic                       hclk,
    input  logic                       hresetn,
    input  logic                       hsel,
    input  logic [1:0]                 htrans,
    input  logic                       hwrite,
    input  logic [2:0]                 hsize,
    input  logic [31:0]                haddr,
    input  logic [SRAM_DATA_WIDTH-1:0] hwdata,
    input  logic                       hready,
    output logic                       hready_resp,
    output logic [1:0]                 hresp,
    output logic [SRAM_DATA_WIDTH-1:0] hrdata,
    output logic [3:0]                 sram_cb_n,
    output logic [3:0]                 sram_cs_n,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic                       sram_write_n,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata
);

    localparam int unsigned NLANES = SRAM_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE, WR, RMW_RD, RMW_WR, RD, RD_DEF, ERR1, ERR2
    } state_t;

    state_t state, state_nxt;

    logic [SRAM_ADDR_WIDTH-1:0] a_addr;
    logic [1:0]                 a_bank;
    logic [1:0]                 a_lane;
    logic                       a_byte;

    logic                       take;
    logic                       illegal;
    logic                       port_busy;
    logic                       rd_now;
    logic [1:0]                 h_bank;
    logic [NLANES-1:0]          lane_sel;
    logic [SRAM_DATA_WIDTH-1:0] merged;
    logic                       unused_bits;

    assign unused_bits = &{1'b0, htrans[0], haddr[31:SRAM_ADDR_WIDTH+4]};

    assign h_bank    = haddr[SRAM_ADDR_WIDTH+3:SRAM_ADDR_WIDTH+2];
    assign take      = hsel & htrans[1] & hready & hready_resp;
    assign illegal   = (hsize > 3'd2) ||
                       ((hsize == 3'd1) && haddr[0]) ||
                       ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    assign port_busy = (state == WR) || (state == RMW_WR);
    assign rd_now    = take && !illegal && !hwrite && !port_busy;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state  <= IDLE;
            a_addr <= '0;
            a_bank <= '0;
            a_lane <= '0;
            a_byte <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                a_addr <= haddr[SRAM_ADDR_WIDTH+1:2];
                a_bank <= h_bank;
                a_lane <= haddr[1:0];
                a_byte <= (hsize == 3'd0);
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            RMW_RD: state_nxt = RMW_WR;
            RD_DEF: state_nxt = RD;
            ERR1:   state_nxt = ERR2;
            default: begin
                if (take) begin
                    if (illegal)
                        state_nxt = ERR1;
                    else if (hwrite)
                        state_nxt = (hsize == 3'd2) ? WR : RMW_RD;
                    else
                        state_nxt = port_busy ? RD_DEF : RD;
                end
            end
        endcase
    end

    // Little-endian merge: byte uses lane haddr[1:0], halfword uses haddr[1].
    always_comb begin
        lane_sel = '0;
        merged   = '0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            lane_sel[i] = a_byte ? (a_lane == 2'(i)) : (a_lane[1] == i[1]);
            merged[i*8 +: 8] = lane_sel[i] ? hwdata[i*8 +: 8] : sram_rdata[i*8 +: 8];
        end
    end

    always_comb begin
        sram_cb_n    = '1;
        sram_cs_n    = '1;
        sram_addr    = '0;
        sram_write_n = 1'b1;
        sram_wdata   = '0;
        case (state)
            WR, RMW_WR: begin
                sram_cb_n    = ~(4'b0001 << a_bank);
                sram_cs_n    = sram_cb_n;
                sram_addr    = a_addr;
                sram_write_n = 1'b0;
                sram_wdata   = (state == WR) ? hwdata : merged;
            end
            RMW_RD, RD_DEF: begin
                sram_cb_n = ~(4'b0001 << a_bank);
                sram_cs_n = sram_cb_n;
                sram_addr = a_addr;
            end
            default: begin
                if (rd_now) begin
                    sram_cb_n = ~(4'b0001 << h_bank);
                    sram_cs_n = sram_cb_n;
                    sram_addr = haddr[SRAM_ADDR_WIDTH+1:2];
                end
            end
        endcase
    end

    always_comb begin
        hready_resp = !((state == RMW_RD) || (state == RD_DEF) || (state == ERR1));
        hresp       = ((state == ERR1) || (state == ERR2)) ? 2'b01 : 2'b00;
        hrdata      = (state == RD) ? sram_rdata : '0;
    end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
AHB-Lite slave that initiates every access on the four-bank SRAM array interface (sram_cb_n/sram_cs_n/sram_addr/sram_write_n/sram_wdata out, sram_rdata in). It sits between the AHB fabric and the SRAM bank top. Word accesses complete with zero wait states. Byte and halfword writes use read-modify-write, because the array has no byte enables. Reads that collide with a write on the single SRAM port are deferred by one cycle.

Parameters:
SRAM_ADDR_WIDTH, 12, word address width per bank; banks are selected by haddr[SRAM_ADDR_WIDTH+3:SRAM_ADDR_WIDTH+2].
SRAM_DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
hclk  in  1  clock; one clock, also drives sram_clk externally.
hresetn  in  1  asynchronous active-low reset.
hsel  in  1  slave select.
htrans  in  2  AHB transfer type.
hwrite  in  1  1 = write.
hsize  in  3  transfer size.
haddr  in  32  byte address.
hwdata  in  32  write data; valid in the data phase.
hready  in  1  bus ready; an address phase is accepted when hsel & htrans[1] & hready.
hready_resp  out  1  slave ready.
hresp  out  2  00 = OKAY, 01 = ERROR.
hrdata  out  32  read data.
sram_cb_n  out  4  bank select, one-hot-low.
sram_cs_n  out  4  chip select; equal to sram_cb_n during an access, 4'hF otherwise.
sram_addr  out  SRAM_ADDR_WIDTH  word address, haddr[SRAM_ADDR_WIDTH+1:2].
sram_write_n  out  1  0 = write.
sram_wdata  out  32  write data.
sram_rdata  in  32  read data; valid the cycle after a read is issued.

Behaviour:
- Reset (hresetn low, async): state IDLE; hready_resp=1, hresp=00, hrdata=0, sram_cs_n=sram_cb_n=4'hF, sram_write_n=1, sram_addr=0, sram_wdata=0. Any pending transfer is dropped without response.
- Legal transfers:
  - hsize 0, any address.
  - hsize 1 with haddr[0]=0.
  - hsize 2 with haddr[1:0]=0.
  - Anything else, including hsize>2, gets a two-cycle ERROR: ERR1 drives hready_resp=0, hresp=01; ERR2 drives hready_resp=1, hresp=01. No SRAM access occurs.
- IDLE/BUSY transfers and hsel=0: no access, OKAY, zero wait.
- The address phase is registered (addr, bank, size, write) on acceptance.
- States: IDLE, WR, RMW_RD, RMW_WR, RD, RD_DEF, ERR1, ERR2.
- Read, port free (state not WR or RMW_WR):
  - In the address-phase cycle, drive cb_n/cs_n for the bank, sram_addr, write_n=1 combinationally.
  - Next state RD: hrdata = sram_rdata, hready_resp=1. Zero wait.
- Read accepted during WR or RMW_WR:
  - Next state RD_DEF: hready_resp=0, read issued from the registered address.
  - Then RD. One wait.
- Word write: state WR issues the write (write_n=0, sram_wdata=hwdata) in the data-phase cycle, hready_resp=1.
- Sub-word write:
  - RMW_RD: hready_resp=0, read of the registered word.
  - RMW_WR: write of merged data, hready_resp=1.
  - Merge is little-endian: lanes selected by haddr[1:0] (byte) or haddr[1] (halfword) take hwdata; other lanes take sram_rdata.
  - hwdata is held by the master across the wait.
- Back-to-back writes are pipelined with no bubble. RD followed by any transfer has no bubble.
- hrdata = 0 outside RD.
- sram_cb_n must be valid in every read-issue cycle, because the array registers it to steer sram_rdata.

Test Plan:
- Reset mid-RMW: assert hresetn=0 during RMW_RD -> outputs at reset values immediately; after release a word read of 0x0 completes with zero wait.
- Word write 0xA5A5_5A5A @0x0000_4008, then word read @0x0000_4008 -> sram_cb_n=4'b1101 and sram_addr=12'h002 during both; the read is deferred with exactly 1 wait; hrdata=0xA5A5_5A5A.
- Word write 0x1122_3344 @0x0000_0010; byte write 0xFF on lane 1 @0x0000_0011 -> 1 wait state; a subsequent read returns 0x1122_FF44.
- Halfword write 0xBEEF in the upper lanes @0x0000_C002 after 0 init -> bank 3 (sram_cb_n=4'b0111); a subsequent read returns 0xBEEF_0000.
- Halfword @0x0000_0001 and hsize=3 @0x0 -> two-cycle ERROR each: hready_resp 0 then 1, hresp=01; no sram_cs_n assertion.
- 4 back-to-back word reads across banks 0–3 -> zero wait, correct data per bank; sram_cs_n=4'hF after the last.
